opera_bus_arbiter: RTL and testbench
====================================

// Module: opera_bus_arbiter
// PURPOSE
//  Shares the system Wishbone bus between the ZAP CPU (master 0) and a DMA engine (master 1).
//  Decodes each access to the MADAM regs, CLIO regs, fixed-data stub locations, or external memory/BIOS.
//  Sequences the register strobes and the external handshake, then returns registered data and a one-cycle ack.
//  Sits between zap_top/DMA and madam/clio/external memory in core_3do.
// PARAMETERS
//  TIMEOUT    256           external-ack timeout, in cycles (>=2)
//  TO_W       8             timeout counter width; must hold TIMEOUT-1
//  STUB_DATA  32'hBADACCE5  read data for 0x0320_6100 and 0x0320_6900
//  ERR_DATA   32'hDEADBEEF  read data returned on timeout
// PORTS
//  i_clk      in   1   system clock; all state changes on rising edge
//  i_reset    in   1   synchronous, active-high reset
//  m0_cyc/m0_stb/m0_we  in  1   CPU Wishbone cycle, strobe, write enable
//  m0_adr, m0_dat       in  32  CPU address, write data
//  m0_sel     in   4   CPU byte selects
//  m0_ack     out  1   CPU ack
//  m0_rdat    out  32  CPU read data
//  m1_*       -    -   DMA master; same set as m0_*
//  slv_adr, slv_dat     out 32  latched address, write data to all slaves
//  slv_sel    out  4   latched byte selects
//  madam_rd, madam_wr   out 1   one-cycle MADAM register strobes
//  clio_rd, clio_wr     out 1   one-cycle CLIO register strobes
//  madam_dout, clio_dout in 32  register read data, valid the cycle after the strobe
//  ext_cyc/ext_stb/ext_we out 1 external-bus handshake
//  ext_ack    in   1   external ack
//  ext_dat    in   32  external read data
//  grant      out  2   one-hot owner: [0]=CPU, [1]=DMA, 00=idle
//  bus_err    out  1   sticky timeout flag
//  err_clr    in   1   clears bus_err
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; last_grant=DMA, so the CPU wins the first tie.
//  Reset mid-transfer: ext_cyc/ext_stb drop on the same edge; no ack is issued.
//  Decode (compare full 32 bits):
//    MADAM 0x0330_0000..0x0330_FFFF; CLIO 0x0340_0000..0x0340_FFFF
//    STUB 0x0320_6100 and 0x0320_6900 -> STUB_DATA; ZERO 0x0320_02B4 -> 0
//    all other addresses -> EXT
//  FSM:
//  IDLE: request = cyc&stb.
//    If locked (the previous owner still holds cyc), only that master is considered.
//    Else one requester wins; if both request, the one not in last_grant wins.
//    On a win: latch adr/dat/sel/we/region, set grant and last_grant -> ACCESS.
//  ACCESS (exactly 1 cycle):
//    MADAM/CLIO: pulse the matching rd/wr strobe -> RESP.
//    STUB/ZERO: no slave activity -> RESP.
//    EXT: raise ext_cyc/ext_stb/ext_we, clear the timeout counter -> EXT_WAIT.
//  EXT_WAIT: hold ext_*.
//    ext_ack: capture ext_dat, drop ext_* -> RESP.
//    Counter reaches TIMEOUT-1 without ack: load ERR_DATA, set bus_err, drop ext_* -> RESP.
//    Owner drops cyc: drop ext_*, clear grant, no ack -> IDLE.
//    ext_ack in the same cycle as the timeout: the ack wins; no error.
//  RESP (exactly 1 cycle): owner ack=1, rdat valid. Read data source by region:
//    MADAM/CLIO: dout sampled this cycle. STUB: STUB_DATA. ZERO: 0. EXT: captured data.
//    Writes return rdat=0.
//    Next state IDLE; lock=1 if the owner's cyc is still high, else grant cleared.
//  Latency, stb sampled in IDLE at cycle N:
//    MADAM/CLIO/STUB/ZERO -> ack at N+2.
//    EXT -> ack at N+3+k, where k = cycles of ext_ack delay after ext_stb rises.
//  Ack/rdat go to the owner only; the other master's ack stays 0.
//  bus_err: err_clr clears it; a timeout in the same cycle as err_clr leaves it set.
// STRUCTURE
//  opera_bus_pkg: region enum (MADAM, CLIO, STUB, ZERO, EXT), FSM state enum, address-range constants.
//  One sub-module, opera_bus_decode: combinational addr[31:0] -> region.
//  FSM, latches, timeout counter and round-robin pointer stay in opera_bus_arbiter.
// TESTING
//  1. CPU reads 0x0330_0004, madam_dout=0x1234_5678
//     -> madam_rd one cycle; m0_ack at N+2; m0_rdat=0x1234_5678.
//  2. CPU and DMA both stb from reset
//     -> CPU served first, then DMA; the next simultaneous pair alternates.
//  3. CPU holds cyc across two reads while DMA requests
//     -> DMA waits until CPU cyc drops (lock).
//  4. DMA reads 0x0000_1000, ext_ack after 3 cycles
//     -> m1_ack at N+6 with ext_dat; bus_err=0.
//  5. Ext read, no ack, TIMEOUT=8 -> ext_cyc low after 8 EXT_WAIT cycles;
//     rdat=0xDEADBEEF; bus_err=1 until err_clr.
//  6. i_reset in EXT_WAIT -> next edge: ext_cyc=0, grant=00, no ack;
//     a CPU read of 0x0320_6100 then returns 0xBADACCE5.

Source files
------------

// File: rtl/opera_bus_pkg.sv
// Shared types and address map for the Opera system-bus arbiter.
// Region and FSM state encodings are used by the arbiter and its address decoder.
package opera_bus_pkg;

   typedef enum logic [2:0] {
      REG_MADAM,
      REG_CLIO,
      REG_STUB,
      REG_ZERO,
      REG_EXT
   } region_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_EXT_WAIT,
      ST_RESP
   } state_t;

   localparam logic [15:0] MADAM_PAGE = 16'h0330;
   localparam logic [15:0] CLIO_PAGE  = 16'h0340;
   localparam logic [31:0] STUB_ADR_A = 32'h0320_6100;
   localparam logic [31:0] STUB_ADR_B = 32'h0320_6900;
   localparam logic [31:0] ZERO_ADR   = 32'h0320_02B4;

endpackage

// File: rtl/opera_bus_decode.sv
// Combinational address decoder: maps a full 32-bit bus address to its target region.
// Anything that is not a register page or a fixed-data location goes to external memory.
module opera_bus_decode
   import opera_bus_pkg::*;
(
   input  logic [31:0] addr,
   output region_t     region
);

   always_comb begin
      region = REG_EXT;
      if (addr[31:16] == MADAM_PAGE)
         region = REG_MADAM;
      else if (addr[31:16] == CLIO_PAGE)
         region = REG_CLIO;
      else if ((addr == STUB_ADR_A) || (addr == STUB_ADR_B))
         region = REG_STUB;
      else if (addr == ZERO_ADR)
         region = REG_ZERO;
   end

endmodule

// File: rtl/opera_bus_arbiter.sv
// Two-master Wishbone arbiter (CPU = master 0, DMA = master 1) with region decode,
// register strobes, external handshake with timeout, and a one-cycle registered response.
//
//  state       | meaning
//  ST_IDLE     | arbitrate; a locked owner keeps the bus while its cyc stays high
//  ST_ACCESS   | one cycle: register strobe, or launch the external cycle
//  ST_EXT_WAIT | external cycle in flight; wait for ack, timeout or abandon
//  ST_RESP     | one cycle: ack and read data to the owner
module opera_bus_arbiter
   import opera_bus_pkg::*;
#(
   parameter int          TIMEOUT   = 256,
   parameter int          TO_W      = 8,
   parameter logic [31:0] STUB_DATA = 32'hBADACCE5,
   parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        m0_cyc,
   input  logic        m0_stb,
   input  logic        m0_we,
   input  logic [31:0] m0_adr,
   input  logic [31:0] m0_dat,
   input  logic [3:0]  m0_sel,
   output logic        m0_ack,
   output logic [31:0] m0_rdat,
   input  logic        m1_cyc,
   input  logic        m1_stb,
   input  logic        m1_we,
   input  logic [31:0] m1_adr,
   input  logic [31:0] m1_dat,
   input  logic [3:0]  m1_sel,
   output logic        m1_ack,
   output logic [31:0] m1_rdat,
   output logic [31:0] slv_adr,
   output logic [31:0] slv_dat,
   output logic [3:0]  slv_sel,
   output logic        madam_rd,
   output logic        madam_wr,
   output logic        clio_rd,
   output logic        clio_wr,
   input  logic [31:0] madam_dout,
   input  logic [31:0] clio_dout,
   output logic        ext_cyc,
   output logic        ext_stb,
   output logic        ext_we,
   input  logic        ext_ack,
   input  logic [31:0] ext_dat,
   output logic [1:0]  grant,
   output logic        bus_err,
   input  logic        err_clr
);

   state_t            state, state_n;
   logic [1:0]        grant_n;
   logic              lock, lock_n;
   logic              last_dma;
   logic              we_q;
   region_t           region_q, win_region;
   logic [TO_W-1:0]   to_cnt;
   logic [31:0]       ext_data_q;
   logic [31:0]       resp_data;
   logic [31:0]       win_adr;
   logic              win, pick;
   logic              ext_capture, ext_err;
   logic              req0, req1, owner_cyc, owner_req;

   assign req0      = m0_cyc & m0_stb;
   assign req1      = m1_cyc & m1_stb;
   assign owner_cyc = grant[1] ? m1_cyc : m0_cyc;
   assign owner_req = grant[1] ? req1 : req0;
   assign win_adr   = pick ? m1_adr : m0_adr;

   opera_bus_decode u_decode (
      .addr   (win_adr),
      .region (win_region)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= ST_IDLE;
         grant <= 2'b00;
         lock  <= 1'b0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         lock  <= lock_n;
      end
   end

   always_comb begin
      state_n     = state;
      grant_n     = grant;
      lock_n      = lock;
      win         = 1'b0;
      pick        = 1'b0;
      ext_capture = 1'b0;
      ext_err     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (lock && owner_cyc) begin
               if (owner_req) begin
                  win  = 1'b1;
                  pick = grant[1];
               end
            end else begin
               lock_n  = 1'b0;
               grant_n = 2'b00;
               if (req0 && req1) begin
                  win  = 1'b1;
                  pick = ~last_dma;
               end else if (req0 || req1) begin
                  win  = 1'b1;
                  pick = req1;
               end
            end
            if (win) begin
               state_n = ST_ACCESS;
               grant_n = pick ? 2'b10 : 2'b01;
               lock_n  = 1'b0;
            end
         end
         ST_ACCESS: begin
            state_n = (region_q == REG_EXT) ? ST_EXT_WAIT : ST_RESP;
         end
         ST_EXT_WAIT: begin
            // ack beats a coincident timeout
            if (ext_ack) begin
               ext_capture = 1'b1;
               state_n     = ST_RESP;
            end else if (to_cnt == '0) begin
               ext_err = 1'b1;
               state_n = ST_RESP;
            end else if (!owner_cyc) begin
               state_n = ST_IDLE;
               grant_n = 2'b00;
            end
         end
         ST_RESP: begin
            state_n = ST_IDLE;
            if (owner_cyc)
               lock_n = 1'b1;
            else
               grant_n = 2'b00;
         end
         default: begin
            state_n = ST_IDLE;
            grant_n = 2'b00;
            lock_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         last_dma   <= 1'b1;
         slv_adr    <= '0;
         slv_dat    <= '0;
         slv_sel    <= '0;
         we_q       <= 1'b0;
         region_q   <= REG_MADAM;
         to_cnt     <= '0;
         ext_data_q <= '0;
         bus_err    <= 1'b0;
      end else begin
         if (win) begin
            last_dma <= pick;
            slv_adr  <= win_adr;
            slv_dat  <= pick ? m1_dat : m0_dat;
            slv_sel  <= pick ? m1_sel : m0_sel;
            we_q     <= pick ? m1_we : m0_we;
            region_q <= win_region;
         end
         // down-counter: terminal count 0 marks the last EXT_WAIT cycle
         if (state == ST_ACCESS)
            to_cnt <= TO_W'(TIMEOUT - 1);
         else if ((state == ST_EXT_WAIT) && (to_cnt != '0))
            to_cnt <= to_cnt - 1'b1;
         if (ext_capture)
            ext_data_q <= ext_dat;
         else if (ext_err)
            ext_data_q <= ERR_DATA;
         if (ext_err)
            bus_err <= 1'b1;
         else if (err_clr)
            bus_err <= 1'b0;
      end
   end

   always_comb begin
      resp_data = '0;
      if (!we_q) begin
         case (region_q)
            REG_MADAM: resp_data = madam_dout;
            REG_CLIO:  resp_data = clio_dout;
            REG_STUB:  resp_data = STUB_DATA;
            REG_ZERO:  resp_data = '0;
            default:   resp_data = ext_data_q;
         endcase
      end
   end

   assign madam_rd = (state == ST_ACCESS) && (region_q == REG_MADAM) && !we_q;
   assign madam_wr = (state == ST_ACCESS) && (region_q == REG_MADAM) &&  we_q;
   assign clio_rd  = (state == ST_ACCESS) && (region_q == REG_CLIO)  && !we_q;
   assign clio_wr  = (state == ST_ACCESS) && (region_q == REG_CLIO)  &&  we_q;

   assign ext_cyc  = (state == ST_EXT_WAIT);
   assign ext_stb  = (state == ST_EXT_WAIT);
   assign ext_we   = (state == ST_EXT_WAIT) && we_q;

   assign m0_ack   = (state == ST_RESP) && grant[0];
   assign m1_ack   = (state == ST_RESP) && grant[1];
   assign m0_rdat  = m0_ack ? resp_data : '0;
   assign m1_rdat  = m1_ack ? resp_data : '0;

endmodule

// File: tb/tb_opera_bus_arbiter.sv
// Directed bench for opera_bus_arbiter: drives both masters and a model external slave
// on the falling edge and checks latency, data, strobes and arbitration order.
module tb_opera_bus_arbiter;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        cyc [2];
   logic        stb [2];
   logic        we [2];
   logic [31:0] adr [2];
   logic [31:0] dat [2];
   logic [3:0]  sel [2];
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdat, m1_rdat;
   logic [31:0] slv_adr, slv_dat;
   logic [3:0]  slv_sel;
   logic        madam_rd, madam_wr, clio_rd, clio_wr;
   logic [31:0] madam_dout, clio_dout;
   logic        ext_cyc, ext_stb, ext_we;
   logic        ext_ack = 1'b0;
   logic [31:0] ext_dat;
   logic [1:0]  grant;
   logic        bus_err;
   logic        err_clr;

   int n_cmp = 0;
   int n_bad = 0;
   int ext_delay = -1;
   int ext_seen = 0;
   int n_ack0 = 0, n_ack1 = 0, n_madam_rd = 0, n_clio_wr = 0, n_ext_stb = 0, n_ext_we = 0;

   always #5 i_clk = ~i_clk;

   opera_bus_arbiter #(
      .TIMEOUT   (8),
      .TO_W      (3),
      .STUB_DATA (32'hBADACCE5),
      .ERR_DATA  (32'hDEADBEEF)
   ) dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .m0_cyc     (cyc[0]),
      .m0_stb     (stb[0]),
      .m0_we      (we[0]),
      .m0_adr     (adr[0]),
      .m0_dat     (dat[0]),
      .m0_sel     (sel[0]),
      .m0_ack     (m0_ack),
      .m0_rdat    (m0_rdat),
      .m1_cyc     (cyc[1]),
      .m1_stb     (stb[1]),
      .m1_we      (we[1]),
      .m1_adr     (adr[1]),
      .m1_dat     (dat[1]),
      .m1_sel     (sel[1]),
      .m1_ack     (m1_ack),
      .m1_rdat    (m1_rdat),
      .slv_adr    (slv_adr),
      .slv_dat    (slv_dat),
      .slv_sel    (slv_sel),
      .madam_rd   (madam_rd),
      .madam_wr   (madam_wr),
      .clio_rd    (clio_rd),
      .clio_wr    (clio_wr),
      .madam_dout (madam_dout),
      .clio_dout  (clio_dout),
      .ext_cyc    (ext_cyc),
      .ext_stb    (ext_stb),
      .ext_we     (ext_we),
      .ext_ack    (ext_ack),
      .ext_dat    (ext_dat),
      .grant      (grant),
      .bus_err    (bus_err),
      .err_clr    (err_clr)
   );

   // External slave: acks ext_delay cycles after it first sees ext_stb (-1 = never)
   always @(negedge i_clk) begin
      ext_ack = 1'b0;
      if (ext_stb) begin
         if (ext_seen == ext_delay) ext_ack = 1'b1;
         ext_seen++;
      end else begin
         ext_seen = 0;
      end
   end

   always @(negedge i_clk) begin
      if (m0_ack)   n_ack0++;
      if (m1_ack)   n_ack1++;
      if (madam_rd) n_madam_rd++;
      if (clio_wr)  n_clio_wr++;
      if (ext_stb)  n_ext_stb++;
      if (ext_we)   n_ext_we++;
   end

   function automatic logic ack_of(input int m);
      return (m == 0) ? m0_ack : m1_ack;
   endfunction

   function automatic logic [31:0] rdat_of(input int m);
      return (m == 0) ? m0_rdat : m1_rdat;
   endfunction

   // Starts and ends on a falling edge; lat = falling edges from request to ack.
   task automatic access(input int m, input logic [31:0] a, input logic w, input logic [31:0] d,
                         input bit hold, output int lat, output logic [31:0] rd);
      cyc[m] = 1'b1; stb[m] = 1'b1; we[m] = w; adr[m] = a; dat[m] = d; sel[m] = 4'hF;
      lat = 0;
      do begin
         @(negedge i_clk);
         lat++;
      end while (!ack_of(m) && lat < 200);
      rd = rdat_of(m);
      stb[m] = 1'b0; we[m] = 1'b0;
      if (!hold) cyc[m] = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; dat[i] = '0; sel[i] = '0;
      end
      repeat (2) @(negedge i_clk);
      i_reset = 1'b0;
   endtask

   task automatic test_reset();
      err_clr = 1'b0; madam_dout = '0; clio_dout = '0; ext_dat = '0;
      do_reset();
      n_cmp++;
      if ({grant, m0_ack, m1_ack, ext_cyc, ext_stb, ext_we, bus_err, madam_rd, madam_wr, clio_rd, clio_wr} !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b required 0", {grant, m0_ack, m1_ack, ext_cyc, ext_stb, ext_we, bus_err, madam_rd, madam_wr, clio_rd, clio_wr});
      end
      n_cmp++;
      if ({slv_adr, slv_dat, slv_sel, m0_rdat, m1_rdat} !== '0) begin
         n_bad++;
         $display("FAIL reset_data: slv_adr=%h slv_dat=%h rdat0=%h rdat1=%h required 0", slv_adr, slv_dat, m0_rdat, m1_rdat);
      end
   endtask

   task automatic test_madam_read();
      int lat; logic [31:0] rd; int r0, a1;
      madam_dout = 32'h1234_5678;
      r0 = n_madam_rd; a1 = n_ack1;
      access(0, 32'h0330_0004, 1'b0, '0, 1'b0, lat, rd);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL madam_latency: got %0d required 2", lat); end
      n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL madam_rdat: got %h required 12345678", rd); end
      n_cmp++; if (n_madam_rd - r0 !== 1) begin n_bad++; $display("FAIL madam_rd_pulse: got %0d cycles required 1", n_madam_rd - r0); end
      n_cmp++; if (n_ack1 !== a1) begin n_bad++; $display("FAIL madam_other_ack: m1_ack pulses %0d required 0", n_ack1 - a1); end
      n_cmp++; if (slv_adr !== 32'h0330_0004) begin n_bad++; $display("FAIL madam_slv_adr: got %h required 03300004", slv_adr); end
   endtask

   task automatic test_clio_write();
      int lat; logic [31:0] rd; int c0, a0;
      clio_dout = 32'h7777_7777;
      c0 = n_clio_wr; a0 = n_ack0;
      access(1, 32'h0340_0010, 1'b1, 32'hCAFE_0001, 1'b0, lat, rd);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL clio_latency: got %0d required 2", lat); end
      n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL clio_write_rdat: got %h required 0", rd); end
      n_cmp++; if (n_clio_wr - c0 !== 1) begin n_bad++; $display("FAIL clio_wr_pulse: got %0d cycles required 1", n_clio_wr - c0); end
      n_cmp++; if ({slv_dat, slv_sel} !== {32'hCAFE_0001, 4'hF}) begin n_bad++; $display("FAIL clio_slv_dat: got %h/%h required cafe0001/f", slv_dat, slv_sel); end
      n_cmp++; if (n_ack0 !== a0) begin n_bad++; $display("FAIL clio_other_ack: m0_ack pulses %0d required 0", n_ack0 - a0); end
   endtask

   task automatic test_decode_bounds();
      int lat; logic [31:0] rd;
      madam_dout = 32'h0000_ABCD;
      access(0, 32'h0320_6900, 1'b0, '0, 1'b0, lat, rd);
      n_cmp++; if ({lat, rd} !== {32'd2, 32'hBADACCE5}) begin n_bad++; $display("FAIL stub_b: lat %0d data %h required 2 badacce5", lat, rd); end
      access(0, 32'h0320_02B4, 1'b0, '0, 1'b0, lat, rd);
      n_cmp++; if ({lat, rd} !== {32'd2, 32'h0}) begin n_bad++; $display("FAIL zero_loc: lat %0d data %h required 2 0", lat, rd); end
      access(1, 32'h0330_FFFF, 1'b0, '0, 1'b0, lat, rd);
      n_cmp++; if ({lat, rd} !== {32'd2, 32'h0000_ABCD}) begin n_bad++; $display("FAIL madam_top: lat %0d data %h required 2 0000abcd", lat, rd); end
      ext_delay = 0; ext_dat = 32'h5A5A_0001;
      access(1, 32'h0331_0000, 1'b0, '0, 1'b0, lat, rd);
      n_cmp++; if ({lat, rd} !== {32'd3, 32'h5A5A_0001}) begin n_bad++; $display("FAIL past_madam_ext: lat %0d data %h required 3 5a5a0001", lat, rd); end
      ext_dat = 32'h5A5A_0002;
      access(0, 32'h0320_6104, 1'b0, '0, 1'b0, lat, rd);
      n_cmp++; if ({lat, rd} !== {32'd3, 32'h5A5A_0002}) begin n_bad++; $display("FAIL near_stub_ext: lat %0d data %h required 3 5a5a0002", lat, rd); end
   endtask

   task automatic test_arbitration();
      int l0, l1; logic [31:0] r0, r1;
      do_reset();
      fork
         access(0, 32'h0320_6100, 1'b0, '0, 1'b0, l0, r0);
         access(1, 32'h0320_02B4, 1'b0, '0, 1'b0, l1, r1);
      join
      n_cmp++; if ({l0, l1} !== {32'd2, 32'd5}) begin n_bad++; $display("FAIL tie_from_reset: cpu lat %0d dma lat %0d required 2 5", l0, l1); end
      n_cmp++; if ({r0, r1} !== {32'hBADACCE5, 32'h0}) begin n_bad++; $display("FAIL tie_from_reset_data: %h %h required badacce5 0", r0, r1); end
      access(0, 32'h0320_6100, 1'b0, '0, 1'b0, l0, r0);
      fork
         access(0, 32'h0320_6100, 1'b0, '0, 1'b0, l0, r0);
         access(1, 32'h0320_6900, 1'b0, '0, 1'b0, l1, r1);
      join
      n_cmp++; if ({l0, l1} !== {32'd5, 32'd2}) begin n_bad++; $display("FAIL tie_after_cpu: cpu lat %0d dma lat %0d required 5 2", l0, l1); end
   endtask

   task automatic test_lock();
      int la, lb, ld; logic [31:0] ra, rb, rdd;
      do_reset();
      fork
         begin
            access(0, 32'h0320_6100, 1'b0, '0, 1'b1, la, ra);
            access(0, 32'h0320_02B4, 1'b0, '0, 1'b1, lb, rb);
            repeat (2) @(negedge i_clk);
            cyc[0] = 1'b0;
         end
         access(1, 32'h0330_0000, 1'b0, '0, 1'b0, ld, rdd);
      join
      n_cmp++; if ({la, lb} !== {32'd2, 32'd2}) begin n_bad++; $display("FAIL lock_cpu_lat: got %0d %0d required 2 2", la, lb); end
      n_cmp++; if (ld !== 10) begin n_bad++; $display("FAIL lock_dma_wait: dma lat %0d required 10", ld); end
   endtask

   task automatic test_ext_read();
      int lat; logic [31:0] rd; int w0;
      ext_delay = 3; ext_dat = 32'h0BAD_F00D;
      access(1, 32'h0000_1000, 1'b0, '0, 1'b0, lat, rd);
      n_cmp++; if ({lat, rd} !== {32'd6, 32'h0BAD_F00D}) begin n_bad++; $display("FAIL ext_read: lat %0d data %h required 6 0badf00d", lat, rd); end
      n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL ext_read_err: bus_err %b required 0", bus_err); end
      ext_delay = 0; w0 = n_ext_we;
      access(0, 32'h1000_0000, 1'b1, 32'h1111_2222, 1'b0, lat, rd);
      n_cmp++; if ({lat, rd, n_ext_we - w0} !== {32'd3, 32'h0, 32'd1}) begin n_bad++; $display("FAIL ext_write: lat %0d data %h we cycles %0d required 3 0 1", lat, rd, n_ext_we - w0); end
   endtask

   task automatic test_timeout();
      int lat; logic [31:0] rd; int s0; logic held;
      ext_delay = -1; s0 = n_ext_stb;
      access(0, 32'h0000_2000, 1'b0, '0, 1'b0, lat, rd);
      n_cmp++; if ({lat, rd} !== {32'd10, 32'hDEADBEEF}) begin n_bad++; $display("FAIL timeout_resp: lat %0d data %h required 10 deadbeef", lat, rd); end
      n_cmp++; if ({n_ext_stb - s0, ext_cyc} !== {32'd8, 1'b0}) begin n_bad++; $display("FAIL timeout_wait: stb cycles %0d ext_cyc %b required 8 0", n_ext_stb - s0, ext_cyc); end
      repeat (3) @(negedge i_clk);
      n_cmp++; if (bus_err !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: bus_err %b required 1", bus_err); end
      err_clr = 1'b1; @(negedge i_clk); err_clr = 1'b0;
      n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL err_clr: bus_err %b required 0", bus_err); end
      ext_delay = 7; ext_dat = 32'h600D_0007;
      access(1, 32'h0000_2004, 1'b0, '0, 1'b0, lat, rd);
      n_cmp++; if ({lat, rd, bus_err} !== {32'd10, 32'h600D_0007, 1'b0}) begin n_bad++; $display("FAIL ack_at_timeout: lat %0d data %h err %b required 10 600d0007 0", lat, rd, bus_err); end
      ext_delay = -1; held = 1'b0;
      fork
         access(0, 32'h0000_2008, 1'b0, '0, 1'b0, lat, rd);
         begin
            err_clr = 1'b1;
            repeat (10) @(negedge i_clk);
            held = bus_err;
            err_clr = 1'b0;
         end
      join
      n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL timeout_vs_clr: bus_err %b required 1", held); end
      err_clr = 1'b1; @(negedge i_clk); err_clr = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd; int a0;
      ext_delay = -1;
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h0000_3000;
      repeat (3) @(negedge i_clk);
      n_cmp++; if (ext_cyc !== 1'b1) begin n_bad++; $display("FAIL mid_ext_active: ext_cyc %b required 1", ext_cyc); end
      a0 = n_ack0;
      i_reset = 1'b1;
      @(negedge i_clk);
      n_cmp++; if ({ext_cyc, ext_stb, grant} !== 4'b0000) begin n_bad++; $display("FAIL mid_reset_drop: ext_cyc %b ext_stb %b grant %b required 0 0 00", ext_cyc, ext_stb, grant); end
      i_reset = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
      @(negedge i_clk);
      n_cmp++; if (n_ack0 !== a0) begin n_bad++; $display("FAIL mid_reset_ack: %0d acks required 0", n_ack0 - a0); end
      access(0, 32'h0320_6100, 1'b0, '0, 1'b0, lat, rd);
      n_cmp++; if ({lat, rd} !== {32'd2, 32'hBADACCE5}) begin n_bad++; $display("FAIL post_reset_stub: lat %0d data %h required 2 badacce5", lat, rd); end
   endtask

   initial begin
      test_reset();
      test_madam_read();
      test_clio_write();
      test_decode_bounds();
      test_arbitration();
      test_lock();
      test_ext_read();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
